// File: rtl/detector_jogada.sv
// detector_jogada: debounced, one-hot validated play detector for the memory game.
// Optional per-play timeout compiled in with `define DETECTOR_JOGADA_TIMEOUT_EN.
module detector_jogada #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic       habilita,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    ESTABILIZA      = 3'd1,
    CAPTURA         = 3'd2,
    INVALIDA        = 3'd3,
    AGUARDA_SOLTURA = 3'd4
  } estado_t;

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

  estado_t       estado;
  logic [3:0]    sinc1;
  logic [3:0]    s;
  logic [3:0]    amostra;
  logic [CW-1:0] cnt;
  logic          um_quente;

  assign um_quente = (amostra != 4'd0) &&
                     ((amostra & (amostra - 4'd1)) == 4'd0);
  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1 <= 4'd0;
      s     <= 4'd0;
    end else begin
      sinc1 <= chaves;
      s     <= sinc1;
    end
  end

  // ESTABILIZA counts matching samples, AGUARDA_SOLTURA counts zero samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      amostra         <= 4'd0;
      cnt             <= '0;
      jogada          <= 4'd0;
      tem_jogada      <= 1'b0;
      jogada_invalida <= 1'b0;
    end else if (zera) begin
      estado          <= OCIOSO;
      amostra         <= 4'd0;
      cnt             <= '0;
      jogada          <= 4'd0;
      tem_jogada      <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      tem_jogada      <= 1'b0;
      jogada_invalida <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (habilita && s != 4'd0 && !timeout) begin
            estado  <= ESTABILIZA;
            amostra <= s;
            cnt     <= CW'(1);
          end
        end
        ESTABILIZA: begin
          if (!habilita || s == 4'd0 || timeout) begin
            estado <= OCIOSO;
            cnt    <= '0;
          end else if (s != amostra) begin
            amostra <= s;
            cnt     <= CW'(1);
          end else if (cnt == CNT_FIM) begin
            cnt <= '0;
            if (um_quente) begin
              estado     <= CAPTURA;
              jogada     <= amostra;
              tem_jogada <= 1'b1;
            end else begin
              estado          <= INVALIDA;
              jogada_invalida <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURA, INVALIDA: begin
          estado <= AGUARDA_SOLTURA;
          cnt    <= '0;
        end
        AGUARDA_SOLTURA: begin
          if (s != 4'd0) begin
            cnt <= '0;
          end else if (cnt == CNT_FIM) begin
            estado <= OCIOSO;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] T_FIM = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else if (zera || !habilita) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else if (tem_jogada || jogada_invalida) begin
      tcnt <= '0;
    end else if (!timeout) begin
      if (tcnt == T_FIM) begin
        timeout <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
`else
  // always 0 for any legal limit; keeps the parameter referenced
  assign timeout = (TIMEOUT_CICLOS < 0);
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed stimulus, run-length reference model,
// per-cycle output compare plus literal expectations.
module tb_detector_jogada;

  localparam int D = 4;
  localparam int T = 3000;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       zera     = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] chaves   = 4'd0;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic       timeout;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_tem = 0;
  int n_inv = 0;
  int tem_cyc = -1;
  int to_cyc  = -1;

  detector_jogada #(
    .DEBOUNCE_CICLOS(D),
    .TIMEOUT_CICLOS (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .zera           (zera),
    .habilita       (habilita),
    .chaves         (chaves),
    .jogada         (jogada),
    .tem_jogada     (tem_jogada),
    .jogada_invalida(jogada_invalida),
    .timeout        (timeout),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nome, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reference model: phases of a play, run lengths of the sampled value
  typedef enum {M_ARM, M_CAP, M_INV, M_WAIT} fase_t;
  fase_t      fase  = M_ARM;
  int         run   = 0;
  int         zrun  = 0;
  int         tcnt  = 0;
  logic [3:0] last  = 4'd0;
  logic [3:0] d1    = 4'd0;
  logic [3:0] d2    = 4'd0;
  logic [3:0] samp;
  logic [3:0] e_jog = 4'd0;
  bit         e_tem = 0;
  bit         e_inv = 0;
  bit         e_to  = 0;
  bit         old_tem, old_inv, old_to;

  function automatic int e_estado();
    case (fase)
      M_ARM:   return (run > 0) ? 1 : 0;
      M_CAP:   return 2;
      M_INV:   return 3;
      default: return 4;
    endcase
  endfunction

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      fase = M_ARM; run = 0; zrun = 0; tcnt = 0; last = 0;
      d1 = 0; d2 = 0; e_jog = 0; e_tem = 0; e_inv = 0; e_to = 0;
    end else begin
      samp = d2; d2 = d1; d1 = chaves;
      old_tem = e_tem; old_inv = e_inv; old_to = e_to;
      e_tem = 0; e_inv = 0;
      if (zera) begin
        fase = M_ARM; run = 0; zrun = 0; tcnt = 0;
        e_to = 0; e_jog = 0;
      end else begin
        case (fase)
          M_ARM: begin
            if (habilita && samp != 0 && !old_to) begin
              if (run > 0 && samp == last) run++;
              else begin run = 1; last = samp; end
              if (run == D) begin
                run = 0;
                if ($countones(last) == 1) begin
                  fase = M_CAP; e_jog = last; e_tem = 1;
                end else begin
                  fase = M_INV; e_inv = 1;
                end
              end
            end else run = 0;
          end
          M_CAP, M_INV: begin fase = M_WAIT; zrun = 0; end
          default: begin
            if (samp == 0) zrun++; else zrun = 0;
            if (zrun == D) begin fase = M_ARM; run = 0; end
          end
        endcase
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
        if (!habilita) begin tcnt = 0; e_to = 0; end
        else if (old_tem || old_inv) tcnt = 0;
        else if (!old_to) begin
          if (tcnt == T - 1) e_to = 1; else tcnt++;
        end
`endif
      end
    end
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (reset) begin
      chk("jogada", jogada, e_jog);
      chk("tem_jogada", tem_jogada, e_tem);
      chk("jogada_invalida", jogada_invalida, e_inv);
      chk("timeout", timeout, e_to);
      chk("db_estado", db_estado, e_estado());
      if (tem_jogada) begin n_tem++; tem_cyc = cyc; end
      if (jogada_invalida) n_inv++;
      if (timeout && to_cyc < 0) to_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int k;
    int zc;
    bit seen;

    #2;
    chk("rst_jogada", jogada, 0);
    chk("rst_tem", tem_jogada, 0);
    chk("rst_inv", jogada_invalida, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_estado", db_estado, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    habilita = 1'b1;
    tick(2);

    // asynchronous reset in the middle of debouncing
    chaves = 4'b0001;
    tick(3);
    chk("mid_estab", db_estado, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_estado", db_estado, 0);
    chk("arst_jogada", jogada, 0);
    chk("arst_tem", tem_jogada, 0);
    chk("arst_inv", jogada_invalida, 0);
    chk("arst_timeout", timeout, 0);
    chaves = 4'd0;
    tick(1);
    reset = 1'b1;
    tick(3);

    // clean press
    n_tem = 0;
    k = cyc;
    chaves = 4'b0001;
    tick(10);
    chaves = 4'd0;
    tick(12);
    chk("clean_count", n_tem, 1);
    chk("clean_latency", tem_cyc, k + 6);
    chk("clean_jogada", jogada, 4'b0001);
    chk("clean_idle", db_estado, 0);

    // bouncing switch
    n_tem = 0;
    for (int i = 0; i < 6; i++) begin
      chaves = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(1);
    end
    chaves = 4'b0100;
    tick(3);
    chk("bounce_quiet", n_tem, 0);
    tick(7);
    chaves = 4'd0;
    tick(12);
    chk("bounce_count", n_tem, 1);
    chk("bounce_jogada", jogada, 4'b0100);

    // two switches at once
    n_tem = 0;
    n_inv = 0;
    chaves = 4'b0110;
    tick(10);
    chaves = 4'd0;
    tick(12);
    chk("inv_count", n_inv, 1);
    chk("inv_no_tem", n_tem, 0);
    chk("inv_jogada", jogada, 4'b0100);

    // disabled, then clear during release wait
    n_tem = 0;
    habilita = 1'b0;
    chaves = 4'b1000;
    tick(10);
    chk("off_count", n_tem, 0);
    habilita = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (db_estado == 3'd4) seen = 1;
    end
    chk("wait_release", seen, 1);
    chk("on_jogada", jogada, 4'b1000);
    chaves = 4'd0;
    zera = 1'b1;
    tick(1);
    zera = 1'b0;
    chk("zera_estado", db_estado, 0);
    chk("zera_jogada", jogada, 0);
    tick(8);

    // clear on the same edge as a capture
    n_tem = 0;
    chaves = 4'b0010;
    tick(5);
    zera = 1'b1;
    chaves = 4'd0;
    tick(1);
    zera = 1'b0;
    tick(8);
    chk("race_no_tem", n_tem, 0);
    chk("race_jogada", jogada, 0);
    chk("race_estado", db_estado, 0);

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    zera = 1'b1;
    tick(1);
    zera = 1'b0;
    zc = cyc;
    to_cyc = -1;
    tick(3200);
    chk("to_level", timeout, 1);
    chk("to_cycle", to_cyc, zc + T);
    n_tem = 0;
    chaves = 4'b0001;
    tick(10);
    chaves = 4'd0;
    tick(8);
    chk("to_ignored", n_tem, 0);
    chk("to_held", timeout, 1);
    zera = 1'b1;
    tick(1);
    zera = 1'b0;
    chk("to_cleared", timeout, 0);
`else
    zc = cyc;
    tick(20);
    chk("to_off_cycles", cyc, zc + 20);
    chk("to_off", timeout, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
